mul_div_unit: RTL and testbench

//  Iterative unsigned multiply/divide unit, downstream of register_bank.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_step.sv | 38 +++
 rtl/mul_div_unit.sv | 110 +++++++++++
 tb/tb_mul_div_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIVU = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        next_hi = '0;
        next_lo = '0;
        if (is_div) begin
            // shifted < 2*divisor, so a non-negative diff always fits WIDTH bits
            if (!diff[WIDTH]) begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULH/DIVU/REMU unit with tagged result for write-back.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Source1,
    input  logic [WIDTH-1:0] Source2,
    input  logic [TAG_W-1:0] Destination,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [TAG_W-1:0] Result_Dest,
    output logic             Div_By_Zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state, state_nxt;
    op_e                op_q;
    logic [TAG_W-1:0]   dest_q;
    logic [WIDTH-1:0]   operand_q, acc_hi, acc_lo;
    logic [WIDTH-1:0]   step_hi, step_lo, calc_result;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   result_q;
    logic [TAG_W-1:0]   result_dest_q;
    logic               dbz_q;
    logic               accept, dbz_in, is_div;

    assign accept = Start && (state != S_CALC);
    assign dbz_in = Op[1] && (Source2 == '0);
    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = dbz_in ? S_DONE : S_CALC;
            S_CALC:  if (count == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = Start ? (dbz_in ? S_DONE : S_CALC) : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        calc_result = step_lo;
        if (op_q == OP_MULH || op_q == OP_REMU) calc_result = step_hi;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q          <= OP_MUL;
            dest_q        <= '0;
            operand_q     <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            count         <= '0;
            result_q      <= '0;
            result_dest_q <= '0;
            dbz_q         <= 1'b0;
        end else if (accept) begin
            // multiply: acc_lo holds the multiplier; divide: acc_lo holds the dividend
            op_q      <= op_e'(Op);
            dest_q    <= Destination;
            operand_q <= Op[1] ? Source2 : Source1;
            acc_hi    <= '0;
            acc_lo    <= Op[1] ? Source1 : Source2;
            count     <= CNT_W'(WIDTH - 1);
            if (dbz_in) begin
                result_q      <= (Op == OP_REMU) ? Source1 : '1;
                result_dest_q <= Destination;
                dbz_q         <= 1'b1;
            end
        end else if (state == S_CALC) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - 1'b1;
            if (count == '0) begin
                result_q      <= calc_result;
                result_dest_q <= dest_q;
                dbz_q         <= 1'b0;
            end
        end
    end

    assign Busy        = (state == S_CALC);
    assign Done        = (state == S_DONE);
    assign Result      = result_q;
    assign Result_Dest = result_dest_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Source1;
    logic [31:0] Source2;
    logic [3:0]  Destination;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [3:0]  Result_Dest;
    logic        Div_By_Zero;

    int n_assert = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(32), .TAG_W(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Op          (Op),
        .Source1     (Source1),
        .Source2     (Source2),
        .Destination (Destination),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .Result_Dest (Result_Dest),
        .Div_By_Zero (Div_By_Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d);
        Op = op; Source1 = a; Source2 = b; Destination = d; Start = 1'b1;
        tick();
        Start = 1'b0;
        Source1 = 32'hDEAD_BEEF;
        Source2 = 32'h1234_5678;
        Destination = 4'hF;
    endtask

    // Called one cycle after the accepting edge; lat counts cycles since Start.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (!Done && lat < 100) begin
            if (Busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] d,
                             input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat, busy_n;
        issue(op, a, b, d);
        wait_done(lat, busy_n);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, Result, exp_res);
        chk({tag, "_dest"}, Result_Dest, d);
        chk({tag, "_dbz"}, Div_By_Zero, exp_dbz);
        tick();
        chk({tag, "_pulse"}, Done, 1'b0);
        chk({tag, "_hold"}, Result, exp_res);
    endtask

    initial begin
        int lat, busy_n, dcount;
        Reset = 1'b1; Start = 1'b0; Op = 2'b00;
        Source1 = '0; Source2 = '0; Destination = '0;
        tick();
        tick();
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_result", Result, 32'h0);
        chk("rst_dest", Result_Dest, 4'h0);
        chk("rst_dbz", Div_By_Zero, 1'b0);
        Reset = 1'b0;
        tick();

        issue(2'b00, 32'd7, 32'd6, 4'd3);
        wait_done(lat, busy_n);
        chk("mul_busy_cycles", busy_n, 32);
        chk("mul_lat", lat, 33);
        chk("mul_res", Result, 32'h0000_002A);
        chk("mul_dest", Result_Dest, 4'd3);
        tick();

        run_check("mulh_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE, 1'b0, 33);
        run_check("mul_ff",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'h0000_0001, 1'b0, 33);
        run_check("mulh_sm", 2'b01, 32'd7, 32'd6, 4'd6, 32'h0, 1'b0, 33);
        run_check("divu",    2'b10, 32'd100, 32'd7, 4'd7, 32'd14, 1'b0, 33);
        run_check("remu",    2'b11, 32'd100, 32'd7, 4'd8, 32'd2, 1'b0, 33);
        run_check("divu_by1", 2'b10, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'hFFFF_FFFF, 1'b0, 33);
        run_check("remu_16", 2'b11, 32'hFFFF_FFFF, 32'h10, 4'd10, 32'hF, 1'b0, 33);
        run_check("divu_big", 2'b10, 32'd5, 32'hFFFF_FFFF, 4'd11, 32'd0, 1'b0, 33);
        run_check("divu_z",  2'b10, 32'd5, 32'd0, 4'd12, 32'hFFFF_FFFF, 1'b1, 1);
        run_check("remu_z",  2'b11, 32'd5, 32'd0, 4'd13, 32'd5, 1'b1, 1);

        // Start while busy must be ignored
        issue(2'b10, 32'd9, 32'd2, 4'd1);
        repeat (4) tick();
        Op = 2'b00; Source1 = 32'd3; Source2 = 32'd3; Destination = 4'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 0;
        while (!Done && lat < 100) begin tick(); lat++; end
        chk("busy_ign_lat", lat + 6, 33);
        chk("busy_ign_res", Result, 32'd4);
        chk("busy_ign_dest", Result_Dest, 4'd1);
        dcount = 0;
        repeat (40) begin tick(); if (Done) dcount++; end
        chk("busy_ign_no2nd", dcount, 0);

        // Reset in cycle 10 of a multiply
        issue(2'b00, 32'd7, 32'd6, 4'd5);
        repeat (9) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        chk("abort_result", Result, 32'h0);
        chk("abort_dest", Result_Dest, 4'h0);
        chk("abort_dbz", Div_By_Zero, 1'b0);
        dcount = 0;
        repeat (40) begin tick(); if (Done) dcount++; end
        chk("abort_no_done", dcount, 0);

        // Back-to-back with Start held through DONE
        Op = 2'b00; Source1 = 32'd7; Source2 = 32'd6; Destination = 4'd1; Start = 1'b1;
        tick();
        wait_done(lat, busy_n);
        chk("b2b_first_lat", lat, 33);
        chk("b2b_first_res", Result, 32'd42);
        Op = 2'b01; Source1 = 32'hFFFF_FFFF; Source2 = 32'hFFFF_FFFF; Destination = 4'd2;
        tick();
        wait_done(lat, busy_n);
        Start = 1'b0;
        chk("b2b_spacing", lat, 33);
        chk("b2b_second_res", Result, 32'hFFFF_FFFE);
        chk("b2b_second_dest", Result_Dest, 4'd2);
        tick();
        chk("b2b_idle_busy", Busy, 1'b0);
        chk("b2b_idle_done", Done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
